// File: rtl/cpu_types_pkg.sv
// Shared core/memory types: RAM handshake encoding, data word and responder FSM states.
// Also provides the width helper used to size the responder's wait counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DACC = 3'd1,
    IACC = 3'd2,
    DHIT = 3'd3,
    IHIT = 3'd4
  } memresp_state_t;

  // Wide enough to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request-unit and RAM-side signal bundle of the memory responder.
// Modport mr is the responder itself; tb is the requester/RAM side.
interface mem_responder_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      ihit;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dhit;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      merr;

  modport mr (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, merr
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, merr
  );

endinterface

// File: rtl/mr_wait_counter.sv
// Saturating RAM-wait counter with synchronous clear; term flags the LIMIT-1 count.
// Zero-latency flag from the registered count; holds at LIMIT-1 instead of wrapping.
module mr_wait_counter
  import cpu_types_pkg::*;
#(
  parameter int unsigned LIMIT = 64,
  parameter int unsigned W     = cnt_width(LIMIT)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == LAST);

endmodule

// File: rtl/mem_responder.sv
// Arbitrates data (priority) and instruction requests onto one RAM port; registered hit/merr pulses.
// Min 3 cycles request-to-IDLE; waits on ramstate, aborts with merr on ERROR or after TIMEOUT wait cycles.
module mem_responder
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            nRST,
  mem_responder_if.mr     bus
);

  memresp_state_t state_q, state_d;
  word_t          iload_q, iload_d;
  word_t          dload_q, dload_d;
  logic           ihit_q, ihit_d;
  logic           dhit_q, dhit_d;
  logic           merr_q, merr_d;
  logic           in_acc;
  logic           wait_term;

  mr_wait_counter #(.LIMIT(TIMEOUT)) u_wait (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (state_d != state_q),
    .en   (in_acc),
    .term (wait_term)
  );

  always_comb begin
    state_d      = state_q;
    iload_d      = iload_q;
    dload_d      = dload_q;
    merr_d       = 1'b0;
    in_acc       = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_d = DACC;
        end else if (bus.iREN) begin
          state_d = IACC;
        end
      end
      DACC: begin
        in_acc       = 1'b1;
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        // A withdrawn request leaves quietly: no hit, no error.
        if (!(bus.dREN || bus.dWEN)) begin
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
          merr_d  = 1'b1;
        end else if (bus.ramstate == ACCESS) begin
          state_d = DHIT;
          if (bus.dREN) begin
            dload_d = bus.ramload;
          end
        end else if (wait_term) begin
          state_d = IDLE;
          merr_d  = 1'b1;
        end
      end
      IACC: begin
        in_acc      = 1'b1;
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == ERROR) begin
          state_d = IDLE;
          merr_d  = 1'b1;
        end else if (bus.ramstate == ACCESS) begin
          state_d = IHIT;
          iload_d = bus.ramload;
        end else if (wait_term) begin
          state_d = IDLE;
          merr_d  = 1'b1;
        end
      end
      DHIT:    state_d = IDLE;
      IHIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ihit_d = (state_d == IHIT);
    dhit_d = (state_d == DHIT);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      merr_q  <= merr_d;
    end
  end

  assign bus.iload = iload_q;
  assign bus.dload = dload_q;
  assign bus.ihit  = ihit_q;
  assign bus.dhit  = dhit_q;
  assign bus.merr  = merr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: bench plays requester and RAM, expected values hand-derived.
module tb_mem_responder;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   nvec;
  int   nerr;

  mem_responder_if bus ();

  mem_responder #(.TIMEOUT(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;

    // Reset held with a data request pending.
    nRST         = 1'b0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b1;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h55;
    bus.dstore   = 32'h77;
    bus.ramload  = 32'hAAAA5555;
    bus.ramstate = ACCESS;
    cyc();
    cyc();
    #1;
    chk("rst_ramREN",   32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr",  bus.ramaddr,     32'd0);
    chk("rst_ramstore", bus.ramstore,    32'd0);
    chk("rst_ihit",     32'(bus.ihit),   32'd0);
    chk("rst_dhit",     32'(bus.dhit),   32'd0);
    chk("rst_merr",     32'(bus.merr),   32'd0);
    chk("rst_iload",    bus.iload,       32'd0);
    chk("rst_dload",    bus.dload,       32'd0);
    nRST         = 1'b1;
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    cyc();

    // Fetch: cycle 0 request, BUSY at 1-2, ACCESS at 3, ihit at 4, IDLE at 5.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h100;
    cyc();
    bus.ramstate = BUSY;
    #1;
    chk("f1_ramREN",  32'(bus.ramREN), 32'd1);
    chk("f1_ramaddr", bus.ramaddr,     32'h100);
    chk("f1_ihit",    32'(bus.ihit),   32'd0);
    cyc();
    #1;
    chk("f2_ramREN",  32'(bus.ramREN), 32'd1);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    #1;
    chk("f3_ihit",    32'(bus.ihit),   32'd0);
    cyc();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    chk("f4_ihit",    32'(bus.ihit),   32'd1);
    chk("f4_iload",   bus.iload,       32'hDEADBEEF);
    chk("f4_ramREN",  32'(bus.ramREN), 32'd0);
    chk("f4_dhit",    32'(bus.dhit),   32'd0);
    cyc();
    #1;
    chk("f5_ihit",    32'(bus.ihit),   32'd0);
    chk("f5_ramREN",  32'(bus.ramREN), 32'd0);

    // Simultaneous I and D: data first, then the fetch.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h104;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h200;
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hCAFE0001;
    #1;
    chk("s1_ramaddr", bus.ramaddr,     32'h200);
    chk("s1_ramREN",  32'(bus.ramREN), 32'd1);
    cyc();
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    chk("s2_dhit",    32'(bus.dhit),   32'd1);
    chk("s2_ihit",    32'(bus.ihit),   32'd0);
    chk("s2_dload",   bus.dload,       32'hCAFE0001);
    chk("s2_ramREN",  32'(bus.ramREN), 32'd0);
    cyc();
    #1;
    chk("s3_dhit",    32'(bus.dhit),   32'd0);
    chk("s3_ramREN",  32'(bus.ramREN), 32'd0);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0BADF00D;
    #1;
    chk("s4_ramREN",  32'(bus.ramREN), 32'd1);
    chk("s4_ramaddr", bus.ramaddr,     32'h104);
    cyc();
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    chk("s5_ihit",    32'(bus.ihit),   32'd1);
    chk("s5_dhit",    32'(bus.dhit),   32'd0);
    chk("s5_iload",   bus.iload,       32'h0BADF00D);
    chk("s5_dload",   bus.dload,       32'hCAFE0001);
    cyc();
    #1;
    chk("s6_ihit",    32'(bus.ihit),   32'd0);

    // Store: write strobe with address/data until ACCESS, dload untouched.
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h40;
    bus.dstore = 32'h12345678;
    cyc();
    bus.ramstate = BUSY;
    #1;
    chk("w1_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("w1_ramREN",   32'(bus.ramREN), 32'd0);
    chk("w1_ramaddr",  bus.ramaddr,     32'h40);
    chk("w1_ramstore", bus.ramstore,    32'h12345678);
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hFFFFFFFF;
    #1;
    chk("w2_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("w2_dhit",     32'(bus.dhit),   32'd0);
    cyc();
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    chk("w3_dhit",     32'(bus.dhit),   32'd1);
    chk("w3_dload",    bus.dload,       32'hCAFE0001);
    chk("w3_ramWEN",   32'(bus.ramWEN), 32'd0);
    cyc();
    #1;
    chk("w4_dhit",     32'(bus.dhit),   32'd0);

    // RAM ERROR: merr pulse, no hit.
    bus.dREN  = 1'b1;
    bus.daddr = 32'h80;
    cyc();
    bus.ramstate = ERROR;
    #1;
    chk("e1_merr",   32'(bus.merr),   32'd0);
    chk("e1_ramREN", 32'(bus.ramREN), 32'd1);
    cyc();
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    chk("e2_merr",   32'(bus.merr),   32'd1);
    chk("e2_dhit",   32'(bus.dhit),   32'd0);
    chk("e2_ramREN", 32'(bus.ramREN), 32'd0);
    cyc();
    #1;
    chk("e3_merr",   32'(bus.merr),   32'd0);

    // Timeout with TIMEOUT=8: eight BUSY wait cycles, then merr.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h300;
    cyc();
    bus.ramstate = BUSY;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t_wait_ramREN", 32'(bus.ramREN), 32'd1);
      chk("t_wait_merr",   32'(bus.merr),   32'd0);
      cyc();
    end
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    #1;
    chk("t9_merr",   32'(bus.merr),   32'd1);
    chk("t9_ihit",   32'(bus.ihit),   32'd0);
    chk("t9_ramREN", 32'(bus.ramREN), 32'd0);
    cyc();
    #1;
    chk("t10_merr",  32'(bus.merr),   32'd0);

    // Reset during IACC: no hit even with ACCESS offered, strobes drop.
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h400;
    cyc();
    bus.ramstate = BUSY;
    #1;
    chk("r1_ramREN", 32'(bus.ramREN), 32'd1);
    nRST = 1'b0;
    cyc();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h11111111;
    #1;
    chk("r2_ramREN", 32'(bus.ramREN), 32'd0);
    chk("r2_ihit",   32'(bus.ihit),   32'd0);
    cyc();
    #1;
    chk("r3_ihit",   32'(bus.ihit),   32'd0);
    chk("r3_iload",  bus.iload,       32'd0);
    chk("r3_dload",  bus.dload,       32'd0);
    nRST         = 1'b1;
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    cyc();
    #1;
    chk("r4_ihit",   32'(bus.ihit),   32'd0);
    chk("r4_ramREN", 32'(bus.ramREN), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
